axis_width_packer: RTL and testbench

//  Downstream stage of fifo_axis: consumes its DATAWIDTH-bit AXI-Stream master port and packs RATIO

---
 rtl/axis_width_packer_pkg.sv | 15 +
 rtl/axis_width_packer.sv | 86 ++++++++
 tb/tb_axis_width_packer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/axis_width_packer_pkg.sv
// Shared definitions for the AXI-Stream width packer: default beat width and counter sizing.
package axis_width_packer_pkg;

    localparam int DEFAULT_DATAWIDTH = 8;

    // Counter width for a 0..n-1 range; never narrower than one bit.
    function automatic int cnt_width(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/axis_width_packer.sv
// Packs RATIO narrow AXI-Stream beats into one wide word and frames every PKT_WORDS words with m_tlast.
module axis_width_packer
    import axis_width_packer_pkg::*;
#(
    parameter int DATAWIDTH = DEFAULT_DATAWIDTH,
    parameter int RATIO     = 4,
    parameter int PKT_WORDS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_tvalid,
    output logic                       s_tready,
    input  logic [DATAWIDTH-1:0]       s_tdata,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic [RATIO*DATAWIDTH-1:0] m_tdata,
    output logic                       m_tlast
);

    localparam int BCW = cnt_width(RATIO);
    localparam int WCW = cnt_width(PKT_WORDS);
    localparam logic [BCW-1:0] BEAT_LAST = BCW'(RATIO - 1);
    localparam logic [WCW-1:0] WORD_LAST = WCW'(PKT_WORDS - 1);

    logic [(RATIO-1)*DATAWIDTH-1:0] staging_r;
    logic [BCW-1:0]                 beat_cnt_r;
    logic [WCW-1:0]                 word_cnt_r;
    logic                           m_tvalid_r;
    logic [RATIO*DATAWIDTH-1:0]     m_tdata_r;
    logic                           m_tlast_r;

    logic s_tready_s;
    logic last_beat_s;
    logic beat_accept_s;
    logic load_s;

    // Completing beat may only enter when the output register is free or draining this cycle.
    always_comb begin
        last_beat_s = (beat_cnt_r == BEAT_LAST);
        if (rst) begin
            s_tready_s = 1'b0;
        end else begin
            s_tready_s = !last_beat_s || !m_tvalid_r || m_tready;
        end
        beat_accept_s = s_tvalid && s_tready_s;
        load_s        = beat_accept_s && last_beat_s;
    end

    // Staging slices and beat counter; the final beat bypasses staging straight into the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            staging_r  <= '0;
            beat_cnt_r <= '0;
        end else if (beat_accept_s) begin
            for (int i = 0; i < RATIO - 1; i++) begin
                if (beat_cnt_r == BCW'(i)) begin
                    staging_r[i*DATAWIDTH +: DATAWIDTH] <= s_tdata;
                end
            end
            beat_cnt_r <= last_beat_s ? '0 : beat_cnt_r + BCW'(1);
        end
    end

    // Output word register and packet framing counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_tvalid_r <= 1'b0;
            m_tdata_r  <= '0;
            m_tlast_r  <= 1'b0;
            word_cnt_r <= '0;
        end else if (load_s) begin
            m_tvalid_r <= 1'b1;
            m_tdata_r  <= {s_tdata, staging_r};
            m_tlast_r  <= (word_cnt_r == WORD_LAST);
            word_cnt_r <= (word_cnt_r == WORD_LAST) ? '0 : word_cnt_r + WCW'(1);
        end else if (m_tvalid_r && m_tready) begin
            m_tvalid_r <= 1'b0;
        end
    end

    assign s_tready = s_tready_s;
    assign m_tvalid = m_tvalid_r;
    assign m_tdata  = m_tdata_r;
    assign m_tlast  = m_tlast_r;

endmodule

// File: tb/tb_axis_width_packer.sv
// Directed and randomized checks of axis_width_packer against a cycle-level scoreboard model.
module tb_axis_width_packer;

    logic        clk;
    logic        rst;
    logic        s_tvalid;
    logic        s_tready;
    logic [7:0]  s_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic [31:0] m_tdata;
    logic        m_tlast;

    axis_width_packer #(.DATAWIDTH(8), .RATIO(4), .PKT_WORDS(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .s_tdata  (s_tdata),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tdata  (m_tdata),
        .m_tlast  (m_tlast)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model state
    int          mbeat;
    int          mword;
    logic        mvalid;
    logic [7:0]  mbuf [3];
    logic [32:0] exp_q [$];   // {tlast, tdata}, front is the word currently on the output
    logic        last_acc;
    int          n_out;

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mbeat  = 0;
        mword  = 0;
        mvalid = 1'b0;
        exp_q.delete();
    endtask

    // One clock: drive inputs just after negedge, check outputs, advance the model to the next negedge.
    task automatic cycle(input logic v, input logic [7:0] d, input logic r);
        logic exp_rdy;
        logic load;
        s_tvalid = v;
        s_tdata  = d;
        m_tready = r;
        #1;
        exp_rdy = (mbeat != 3) || !mvalid || r;
        chk("s_tready", {32'd0, s_tready}, {32'd0, exp_rdy});
        chk("m_tvalid", {32'd0, m_tvalid}, {32'd0, mvalid});
        if (mvalid) begin
            if (exp_q.size() > 0) begin
                chk("word", {m_tlast, m_tdata}, exp_q[0]);
            end else begin
                chk("scoreboard_underflow", 33'd1, 33'd0);
            end
        end
        load     = 1'b0;
        last_acc = v && exp_rdy;
        if (last_acc) begin
            if (mbeat == 3) begin
                exp_q.push_back({(mword == 3), d, mbuf[2], mbuf[1], mbuf[0]});
                mword = (mword == 3) ? 0 : mword + 1;
                mbeat = 0;
                load  = 1'b1;
            end else begin
                mbuf[mbeat] = d;
                mbeat++;
            end
        end
        if (mvalid && r) begin
            if (exp_q.size() > 0) begin
                void'(exp_q.pop_front());
            end
            n_out++;
        end
        if (load) begin
            mvalid = 1'b1;
        end else if (mvalid && r) begin
            mvalid = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        #1;
        chk("s_tready_in_reset", {32'd0, s_tready}, 33'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        chk("reset_state", {m_tvalid, m_tlast, m_tdata}, 34'd0);
    endtask

    initial begin
        logic [7:0] bytes [256];
        int idx;
        int guard;
        clk      = 1'b0;
        rst      = 1'b1;
        s_tvalid = 1'b0;
        s_tdata  = 8'h00;
        m_tready = 1'b0;
        n_out    = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        do_reset();

        // 1: first word, one clock after the fourth beat
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'(i), 1'b1);
        s_tvalid = 1'b0;
        #1;
        chk("t1_word", {m_tvalid, m_tlast, m_tdata}, {1'b1, 1'b0, 32'h03020100});
        cycle(1'b0, 8'h00, 1'b1);

        // 2: continuous stream of 16 bytes, packet framing
        do_reset();
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b1);
        #1;
        chk("t2_last_word", {m_tvalid, m_tlast, m_tdata}, {1'b1, 1'b1, 32'h0F0E0D0C});
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1);

        // 3: output stall; completing beat 7 waits, then enters with the transfer
        do_reset();
        for (int i = 0; i < 7; i++) cycle(1'b1, 8'(i), 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 8'h07, 1'b0);
            chk("t3_byte7_blocked", {32'd0, last_acc}, 33'd0);
        end
        #1;
        chk("t3_held_word", {m_tvalid, m_tdata}, {1'b1, 32'h03020100});
        cycle(1'b1, 8'h07, 1'b1);
        chk("t3_byte7_accepted", {32'd0, last_acc}, 33'd1);
        #1;
        chk("t3_second_word", {m_tvalid, m_tdata}, {1'b1, 32'h07060504});
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1);

        // 4: random gaps on both sides, 256 bytes -> 64 words
        do_reset();
        for (int i = 0; i < 256; i++) bytes[i] = 8'($urandom);
        idx   = 0;
        guard = 0;
        n_out = 0;
        while (idx < 256 && guard < 20000) begin
            cycle(1'($urandom_range(0, 1)), bytes[idx], 1'($urandom_range(0, 1)));
            if (last_acc) idx++;
            guard++;
        end
        chk("t4_all_bytes_sent", 33'(idx), 33'd256);
        for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1);
        chk("t4_word_count", 33'(n_out), 33'd64);
        chk("t4_scoreboard_empty", 33'(exp_q.size()), 33'd0);

        // 5: reset mid-stream discards staged beats and restarts framing
        for (int i = 0; i < 6; i++) cycle(1'b1, 8'hA0 + 8'(i), 1'b0);
        do_reset();
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'h10 + 8'(i), 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1);

        // 6: partial word is never flushed
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'h50 + 8'(i), 1'b1);
        for (int i = 0; i < 50; i++) cycle(1'b0, 8'hFF, 1'b1);
        cycle(1'b1, 8'h53, 1'b1);
        #1;
        chk("t6_completed_word", {m_tvalid, m_tlast, m_tdata}, {1'b1, 1'b0, 32'h53525150});
        for (int i = 0; i < 2; i++) cycle(1'b0, 8'h00, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
